// File: rtl/score_ctrl.sv
// Learn-mode scoring sequencer: accumulates per-note timing error and miss
// penalties into a saturating score, then shows the frozen result for a fixed time.
module score_ctrl #(
    parameter int                   SCORE_W      = 41,
    parameter int                   MISS_WINDOW  = 50_000_000,
    parameter logic [SCORE_W-1:0]   MISS_PENALTY = 41'd1_000_000_000,
    parameter int                   DISP_CYCLES  = 300_000_000,
    parameter int                   CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               note_due,
    input  logic               key_hit,
    input  logic               song_end,
    output logic [SCORE_W-1:0] score,
    output logic               score_valid,
    output logic               busy,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   note_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam int DEV_W = $clog2(MISS_WINDOW + 1);
    localparam int TMR_W = $clog2(DISP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_NOTE = 2'd1,
        TIMING    = 2'd2,
        SHOW      = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [DEV_W-1:0]   dev_reg, dev_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [CNT_W-1:0]   note_cnt_reg, note_cnt_next;
    logic [CNT_W-1:0]   miss_cnt_reg, miss_cnt_next;
    logic               score_valid_reg, score_valid_next;
    logic               busy_reg, busy_next;
    logic               hit_en, miss_en;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            dev_reg         <= '0;
            timer_reg       <= '0;
            score_reg       <= '0;
            note_cnt_reg    <= '0;
            miss_cnt_reg    <= '0;
            score_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            dev_reg         <= dev_next;
            timer_reg       <= timer_next;
            score_reg       <= score_next;
            note_cnt_reg    <= note_cnt_next;
            miss_cnt_reg    <= miss_cnt_next;
            score_valid_reg <= score_valid_next;
            busy_reg        <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        dev_next      = dev_reg;
        timer_next    = timer_reg;
        hit_en        = 1'b0;
        miss_en       = 1'b0;

        if (start) begin
            state_next = WAIT_NOTE;
            dev_next   = '0;
        end else begin
            case (state_reg)
                IDLE: ;
                WAIT_NOTE: begin
                    if (song_end) begin
                        state_next = SHOW;
                        timer_next = '0;
                    end else if (note_due) begin
                        state_next = TIMING;
                        dev_next   = '0;
                    end
                end
                TIMING: begin
                    dev_next = dev_reg + 1'b1;
                    // A hit always wins over miss accounting, even alongside song_end.
                    if (key_hit) begin
                        hit_en = 1'b1;
                        if (song_end) begin
                            state_next = SHOW;
                            timer_next = '0;
                        end else if (note_due) begin
                            dev_next = '0;
                        end else begin
                            state_next = WAIT_NOTE;
                        end
                    end else if (song_end) begin
                        miss_en    = 1'b1;
                        state_next = SHOW;
                        timer_next = '0;
                    end else if (note_due) begin
                        miss_en  = 1'b1;
                        dev_next = '0;
                    end else if (dev_reg == DEV_W'(MISS_WINDOW)) begin
                        miss_en    = 1'b1;
                        state_next = WAIT_NOTE;
                    end
                end
                SHOW: begin
                    if (timer_reg == TMR_W'(DISP_CYCLES - 1)) begin
                        state_next = IDLE;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        score_next    = score_reg;
        note_cnt_next = note_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        if (start) begin
            score_next    = '0;
            note_cnt_next = '0;
            miss_cnt_next = '0;
        end else if (hit_en) begin
            score_next    = sat_add(score_reg, SCORE_W'(dev_reg));
            note_cnt_next = cnt_inc(note_cnt_reg);
        end else if (miss_en) begin
            score_next    = sat_add(score_reg, MISS_PENALTY);
            note_cnt_next = cnt_inc(note_cnt_reg);
            miss_cnt_next = cnt_inc(miss_cnt_reg);
        end

        score_valid_next = (state_next == SHOW);
        busy_next        = (state_next == WAIT_NOTE) || (state_next == TIMING);
    end

    assign score       = score_reg;
    assign score_valid = score_valid_reg;
    assign busy        = busy_reg;
    assign state       = state_reg;
    assign note_cnt    = note_cnt_reg;
    assign miss_cnt    = miss_cnt_reg;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed scenarios then random pulses, checked each cycle
// against an edge-count based reference model (second instance uses a 2^40 penalty).
module tb_score_ctrl;

    localparam int     W     = 10;
    localparam int     P     = 1000;
    localparam int     D     = 20;
    localparam longint PSAT  = 64'd1 << 40;
    localparam longint SMAX  = (64'd1 << 41) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, note_due = 1'b0, key_hit = 1'b0, song_end = 1'b0;
    logic [40:0] score, score_s;
    logic        score_valid, score_valid_s, busy, busy_s;
    logic [1:0]  state, state_s;
    logic [7:0]  note_cnt, note_cnt_s, miss_cnt, miss_cnt_s;

    int checks = 0;
    int errors = 0;

    score_ctrl #(.SCORE_W(41), .MISS_WINDOW(W), .MISS_PENALTY(41'd1000),
                 .DISP_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .note_due(note_due),
        .key_hit(key_hit), .song_end(song_end), .score(score),
        .score_valid(score_valid), .busy(busy), .state(state),
        .note_cnt(note_cnt), .miss_cnt(miss_cnt));

    score_ctrl #(.SCORE_W(41), .MISS_WINDOW(W), .MISS_PENALTY(41'h100_0000_0000),
                 .DISP_CYCLES(D), .CNT_W(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .note_due(note_due),
        .key_hit(key_hit), .song_end(song_end), .score(score_s),
        .score_valid(score_valid_s), .busy(busy_s), .state(state_s),
        .note_cnt(note_cnt_s), .miss_cnt(miss_cnt_s));

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 waiting, 2 timing, 3 showing.
    int     mode = 0;
    longint m_score = 0, m_sat = 0;
    int     m_note = 0, m_miss = 0;
    longint e = 0, open_e = 0, show_e = 0;

    function automatic longint sadd(input longint a, input longint b);
        return (a + b > SMAX) ? SMAX : a + b;
    endfunction

    task automatic m_reset();
        mode = 0; m_score = 0; m_sat = 0; m_note = 0; m_miss = 0;
    endtask

    task automatic m_close(input bit missed, input longint dev);
        m_note = (m_note < 255) ? m_note + 1 : 255;
        if (missed) begin
            m_miss  = (m_miss < 255) ? m_miss + 1 : 255;
            m_score = sadd(m_score, P);
            m_sat   = sadd(m_sat, PSAT);
        end else begin
            m_score = sadd(m_score, dev);
            m_sat   = sadd(m_sat, dev);
        end
    endtask

    task automatic m_edge(input bit st, input bit nd, input bit kh, input bit se);
        longint dev;
        if (st) begin
            m_reset();
            mode = 1;
        end else if (mode == 1) begin
            if (se) begin mode = 3; show_e = e; end
            else if (nd) begin mode = 2; open_e = e; end
        end else if (mode == 2) begin
            dev = e - 1 - open_e;
            if (kh) begin
                m_close(1'b0, dev);
                if (se) begin mode = 3; show_e = e; end
                else if (nd) open_e = e;
                else mode = 1;
            end else if (se) begin
                m_close(1'b1, 0); mode = 3; show_e = e;
            end else if (nd) begin
                m_close(1'b1, 0); open_e = e;
            end else if (dev == W) begin
                m_close(1'b1, 0); mode = 1;
            end
        end else if (mode == 3) begin
            if (e - show_e == D) mode = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".state"},       64'(state),       64'(mode));
        chk({ph, ".score"},       64'(score),       64'(m_score));
        chk({ph, ".score_sat"},   64'(score_s),     64'(m_sat));
        chk({ph, ".score_valid"}, 64'(score_valid), 64'(mode == 3));
        chk({ph, ".busy"},        64'(busy),        64'(mode == 1 || mode == 2));
        chk({ph, ".note_cnt"},    64'(note_cnt),    64'(m_note));
        chk({ph, ".miss_cnt"},    64'(miss_cnt),    64'(m_miss));
    endtask

    task automatic step(input string ph, input bit st, input bit nd, input bit kh, input bit se);
        start = st; note_due = nd; key_hit = kh; song_end = se;
        @(posedge clk);
        e++;
        if (rst_n) m_edge(st, nd, kh, se); else m_reset();
        #1;
        start = 0; note_due = 0; key_hit = 0; song_end = 0;
        check_all(ph);
    endtask

    task automatic idle(input string ph, input int n);
        for (int i = 0; i < n; i++) step(ph, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        // Reset state
        #1 check_all("reset_async");
        step("reset", 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        step("idle", 0, 0, 0, 0);

        // Two hits at dev 4 and 6, then song end and display window
        step("hits", 1, 0, 0, 0);
        step("hits", 0, 1, 0, 0);
        idle("hits", 4);
        step("hits", 0, 0, 1, 0);
        step("hits", 0, 1, 0, 0);
        idle("hits", 6);
        step("hits", 0, 0, 1, 0);
        step("hits_end", 0, 0, 0, 1);
        chk("hits_score_const", 64'(score), 64'd10);
        chk("hits_note_const", 64'(note_cnt), 64'd2);
        n = 0;
        while (score_valid === 1'b1 && n < 40) begin
            n++;
            step("show", 0, 0, 0, 0);
        end
        chk("show_len", 64'(n), 64'(D));
        chk("show_idle_state", 64'(state), 64'd0);
        chk("show_hold_score", 64'(score), 64'd10);

        // Stray inputs in IDLE
        step("stray_idle", 0, 0, 1, 0);
        step("stray_idle", 0, 1, 0, 0);
        idle("stray_idle", 2);
        chk("stray_idle_score", 64'(score), 64'd10);

        // Window expiry miss
        step("miss", 1, 0, 0, 0);
        step("miss", 0, 0, 1, 0);
        step("miss", 0, 1, 0, 0);
        idle("miss", W + 1);
        chk("miss_score_const", 64'(score), 64'd1000);
        chk("miss_cnt_const", 64'(miss_cnt), 64'd1);
        chk("miss_state_const", 64'(state), 64'd1);
        step("miss_stray", 0, 0, 1, 0);
        step("miss_end", 0, 0, 0, 1);
        chk("miss_show_score", 64'(score), 64'd1000);
        idle("miss_show", 3);

        // Restart during SHOW
        step("restart", 1, 0, 0, 0);
        chk("restart_valid", 64'(score_valid), 64'd0);
        chk("restart_score", 64'(score), 64'd0);

        // Hit coincident with note_due, then song_end mid-note
        step("coin", 0, 1, 0, 0);
        idle("coin", 3);
        step("coin", 0, 1, 1, 0);
        chk("coin_score_const", 64'(score), 64'd3);
        idle("coin", 2);
        step("coin_end", 0, 0, 0, 1);
        chk("coin_end_score", 64'(score), 64'd1003);

        // Saturation via repeated note_due misses
        step("sat", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("sat", 0, 1, 0, 0);
        chk("sat_score_max", 64'(score_s), 64'(SMAX));
        step("sat_end", 0, 0, 0, 1);
        idle("sat_show", 2);

        // Asynchronous reset mid-TIMING
        step("rst", 1, 0, 0, 0);
        step("rst", 0, 1, 0, 0);
        idle("rst", 3);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("rst_async");
        @(posedge clk); e++;
        #1 check_all("rst_held");
        rst_n = 1'b1;
        step("rst_after", 0, 0, 1, 0);

        // Random pulses
        for (int i = 0; i < 3000; i++) begin
            step("rand", ($urandom_range(199) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(5) == 0), ($urandom_range(59) == 0));
            if (mode == 0 && $urandom_range(9) == 0) step("rand_start", 1, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Learn-mode scoring sequencer. It measures the player's timing error per note against the song player's expected onsets and accumulates a 41-bit penalty score, where lower is better.
- At song end it freezes the score and drives the score-to-level display path for a fixed time, then returns to idle.
- Sits between the song player / keyboard decoder and the level display converter.

Parameters:
- SCORE_W, 41, score accumulator width; must match the level converter input.
- MISS_WINDOW, 50_000_000, cycles after note_due before the note counts as missed.
- MISS_PENALTY, 41'd1_000_000_000, added to the score for each missed note.
- DISP_CYCLES, 300_000_000, cycles the result stays displayed (3 s at 100 MHz).
- CNT_W, 8, note counter width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a new song and clears the score.
- note_due  input  1  single-cycle pulse from the song player at each expected note onset.
- key_hit  input  1  single-cycle pulse from the keyboard decoder when the correct key is pressed.
- song_end  input  1  single-cycle pulse after the last note.
- score  output  SCORE_W  accumulated penalty; goes to the level converter.
- score_valid  output  1  high while the final result is displayed.
- busy  output  1  high in WAIT_NOTE and TIMING.
- state  output  2  current state encoding, for debug and LEDs.
- note_cnt  output  CNT_W  notes closed (hit or missed) in the current song.
- miss_cnt  output  CNT_W  notes missed in the current song.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; score=0; score_valid=0; busy=0; note_cnt=0; miss_cnt=0.
  - Internal deviation counter (dev) and display timer cleared.
- States: IDLE=0, WAIT_NOTE=1, TIMING=2, SHOW=3. All outputs are registered; each effect appears 1 cycle after the triggering input.
- start in any state has top priority:
  - Next cycle: state=WAIT_NOTE; score, note_cnt, miss_cnt and dev cleared; score_valid=0.
- IDLE:
  - Holds the last score.
  - Ignores note_due, key_hit and song_end.
- WAIT_NOTE:
  - note_due -> TIMING with dev=0.
  - key_hit -> ignored (no pending note).
  - song_end -> SHOW.
- TIMING:
  - dev increments each cycle.
  - key_hit -> score += dev; note_cnt++.
    - A key_hit in the same cycle as entry yields dev=0 (perfect hit).
    - Next state is WAIT_NOTE, or TIMING with dev=0 if note_due is also asserted that cycle.
  - dev reaching MISS_WINDOW with no key_hit -> score += MISS_PENALTY; note_cnt++; miss_cnt++; next state WAIT_NOTE.
    - If note_due is also asserted that cycle, the miss is charged and TIMING restarts with dev=0.
  - note_due without key_hit -> the current note is charged as a miss and TIMING restarts with dev=0.
  - song_end -> the outstanding note is charged as a miss, then SHOW. song_end takes priority over note_due.
  - Simultaneous key_hit and song_end -> the hit is scored (dev, not penalty), then SHOW.
- SHOW:
  - score_valid=1; score frozen.
  - Timer counts DISP_CYCLES, then -> IDLE with score_valid=0.
  - Inputs other than start are ignored.
- Arithmetic:
  - Score additions saturate at 2^SCORE_W-1; no wrap.
  - dev is zero-extended to SCORE_W before the add.
  - note_cnt and miss_cnt saturate at all-ones.
- busy = (state==WAIT_NOTE || state==TIMING).
- Reset asserted mid-song or mid-display returns to the reset values immediately. No partial score is retained.

Test Plan:
(Bench parameters: MISS_WINDOW=10, MISS_PENALTY=1000, DISP_CYCLES=20.)
- Hits: start, then note_due; key_hit 4 cycles later; note_due; key_hit 6 cycles later; song_end -> score=10, note_cnt=2, miss_cnt=0, score_valid high for exactly 20 cycles, then state=IDLE with score still 10.
- Miss: start, note_due, no key_hit -> at window expiry score=1000, miss_cnt=1, state=WAIT_NOTE; then song_end -> SHOW with score=1000.
- Coincident events:
  - key_hit with note_due in the same cycle (dev=3) -> score=3 and TIMING restarts at dev=0.
  - song_end during TIMING -> score +1000 and miss_cnt increments.
- Saturation: preload the score near max via repeated misses with MISS_PENALTY forced to 2^40 -> score stops at 2^41-1 and does not wrap.
- Restart and reset:
  - start during SHOW -> score_valid drops next cycle; score=0; state=WAIT_NOTE.
  - rst_n low mid-TIMING -> all outputs reach reset values without waiting for a clock edge.
- Stray inputs: key_hit in WAIT_NOTE or IDLE, and note_due in IDLE -> no change to score or counters.
